// File: rtl/pc_pkg.sv
// Shared constants, fetch-sequencer states and address helpers for the PC/fetch block.
package pc_pkg;

  localparam int PC_W             = 16;
  localparam int INSTR_W          = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int INC              = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Branch targets are halfword aligned, so bit 0 is always dropped.
  function automatic logic [PC_W-1:0] even_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential next-PC adder; wraps modulo 2^PC_W.
module pc_incr
  import pc_pkg::*;
(
  input  logic [PC_W-1:0] base,
  output logic [PC_W-1:0] sum
);

  assign sum = base + PC_W'(INC);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and single-outstanding instruction fetch sequencer with branch redirect.
module pc_fetch_ctrl
  import pc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc
);

  fetch_state_t    state, state_nxt, resume;
  logic [PC_W-1:0] pc_nxt, pc_plus, req_pc, req_pc_nxt, target;
  logic            discard, discard_nxt, capture;

  pc_incr u_pc_incr (
    .base (pc),
    .sum  (pc_plus)
  );

  assign target      = even_pc(redirect_pc);
  assign resume      = en ? REQ : IDLE;
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      discard    <= 1'b0;
      instr_data <= '0;
      instr_pc   <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      req_pc  <= req_pc_nxt;
      discard <= discard_nxt;
      if (capture) begin
        instr_data <= imem_rdata;
        instr_pc   <= req_pc;
      end
    end
  end

  // Redirect is checked first in every state; a granted fetch that races a
  // redirect still counts as outstanding and its data is dropped on return.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    req_pc_nxt  = req_pc;
    discard_nxt = discard;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) pc_nxt = target;
        else if (en)        state_nxt = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          state_nxt  = WAIT;
          req_pc_nxt = pc;
          if (redirect_valid) begin
            pc_nxt      = target;
            discard_nxt = 1'b1;
          end else begin
            pc_nxt = pc_plus;
          end
        end else if (redirect_valid) begin
          pc_nxt = target;
        end else if (!en) begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt = target;
          if (imem_rvalid) begin
            discard_nxt = 1'b0;
            state_nxt   = resume;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = resume;
          end else begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = target;
          state_nxt = resume;
        end else if (instr_ready) begin
          state_nxt = resume;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: flag-based fetch model checked every cycle plus literal spot checks.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] pc;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  // Transaction-level model: "wanting to fetch", "fetch in flight", "flight
  // is stale" and "holding an instruction for decode".
  bit          m_want = 1'b0;
  bit          m_fly = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_have = 1'b0;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_fly_pc = 16'h0000;
  logic [15:0] m_data = 16'h0000;
  logic [15:0] m_ipc = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] tgt;
    if (!rst_n) begin
      m_want = 0; m_fly = 0; m_stale = 0; m_have = 0;
      m_pc = 16'h0000; m_fly_pc = 16'h0000; m_data = 16'h0000; m_ipc = 16'h0000;
    end else begin
      tgt = redirect_pc & 16'hFFFE;
      if (m_have) begin
        if (redirect_valid || instr_ready) begin
          m_have = 0;
          m_want = en;
        end
        if (redirect_valid) m_pc = tgt;
      end else if (m_fly) begin
        if (imem_rvalid) begin
          m_fly = 0;
          if (m_stale || redirect_valid) begin
            m_stale = 0;
            m_want  = en;
          end else begin
            m_have = 1;
            m_data = imem_rdata;
            m_ipc  = m_fly_pc;
          end
        end else if (redirect_valid) begin
          m_stale = 1;
        end
        if (redirect_valid) m_pc = tgt;
      end else if (m_want) begin
        if (imem_gnt) begin
          m_want   = 0;
          m_fly    = 1;
          m_fly_pc = m_pc;
          m_stale  = redirect_valid;
          m_pc     = redirect_valid ? tgt : m_pc + 16'd2;
        end else if (redirect_valid) begin
          m_pc = tgt;
        end else if (!en) begin
          m_want = 0;
        end
      end else begin
        if (redirect_valid) m_pc = tgt;
        else if (en)        m_want = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model imem_req", imem_req, m_want);
    checkOutput("model imem_addr", imem_addr, m_pc);
    checkOutput("model pc", pc, m_pc);
    checkOutput("model instr_valid", instr_valid, m_have);
    checkOutput("model instr_data", instr_data, m_data);
    checkOutput("model instr_pc", instr_pc, m_ipc);
  end

  task automatic applyStimulus(input logic e, input logic g, input logic rv, input logic [15:0] rd,
                               input logic rdy, input logic rdv, input logic [15:0] rpc);
    en = e; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    instr_ready = rdy; redirect_valid = rdv; redirect_pc = rpc;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset imem_req", imem_req, 0);
    checkOutput("reset imem_addr", imem_addr, 16'h0000);
    checkOutput("reset instr_valid", instr_valid, 0);
    rst_n = 1'b1;

    // Basic fetch with immediate gnt/rvalid.
    applyStimulus(1, 0, 0, 16'h0000, 1, 0, 16'h0000);
    checkOutput("first req", imem_req, 1);
    checkOutput("first addr", imem_addr, 16'h0000);
    applyStimulus(1, 1, 0, 16'h0000, 1, 0, 16'h0000);
    checkOutput("pc after gnt", pc, 16'h0002);
    applyStimulus(1, 0, 1, 16'hA5A5, 1, 0, 16'h0000);
    checkOutput("first valid", instr_valid, 1);
    checkOutput("first data", instr_data, 16'hA5A5);
    checkOutput("first ipc", instr_pc, 16'h0000);
    applyStimulus(1, 0, 0, 16'h0000, 1, 0, 16'h0000);
    checkOutput("second addr", imem_addr, 16'h0002);
    applyStimulus(1, 1, 0, 16'h0000, 0, 0, 16'h0000);
    applyStimulus(1, 0, 1, 16'h1357, 0, 0, 16'h0000);
    checkOutput("second ipc", instr_pc, 16'h0002);

    // Decode stalls for four cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 16'h0000, 0, 0, 16'h0000);
      checkOutput("stall valid", instr_valid, 1);
      checkOutput("stall data", instr_data, 16'h1357);
      checkOutput("stall req", imem_req, 0);
    end
    applyStimulus(1, 0, 0, 16'h0000, 1, 0, 16'h0000);
    checkOutput("after stall req", imem_req, 1);
    checkOutput("after stall addr", imem_addr, 16'h0004);

    // Redirect while waiting for data.
    applyStimulus(1, 1, 0, 16'h0000, 1, 0, 16'h0000);
    applyStimulus(1, 0, 0, 16'h0000, 1, 1, 16'h1235);
    checkOutput("wait redirect pc", pc, 16'h1234);
    applyStimulus(1, 0, 1, 16'hDEAD, 1, 0, 16'h0000);
    checkOutput("dropped valid", instr_valid, 0);
    checkOutput("post redirect addr", imem_addr, 16'h1234);
    checkOutput("post redirect req", imem_req, 1);

    // Redirect racing the grant.
    applyStimulus(1, 1, 0, 16'h0000, 1, 1, 16'h0040);
    checkOutput("race pc", pc, 16'h0040);
    checkOutput("race req", imem_req, 0);
    applyStimulus(1, 0, 0, 16'h0000, 1, 0, 16'h0000);
    applyStimulus(1, 0, 1, 16'hBEEF, 1, 0, 16'h0000);
    checkOutput("race dropped", instr_valid, 0);
    checkOutput("race next addr", imem_addr, 16'h0040);

    // Wrap at top of address space.
    applyStimulus(1, 0, 0, 16'h0000, 1, 1, 16'hFFFF);
    checkOutput("top addr", imem_addr, 16'hFFFE);
    applyStimulus(1, 1, 0, 16'h0000, 1, 0, 16'h0000);
    checkOutput("wrap pc", pc, 16'h0000);
    applyStimulus(1, 0, 1, 16'hC3C3, 0, 0, 16'h0000);
    checkOutput("top ipc", instr_pc, 16'hFFFE);
    applyStimulus(1, 0, 0, 16'h0000, 1, 0, 16'h0000);
    checkOutput("wrap addr", imem_addr, 16'h0000);

    // Asynchronous reset while waiting.
    applyStimulus(1, 1, 0, 16'h0000, 1, 0, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async req", imem_req, 0);
    checkOutput("async addr", imem_addr, 16'h0000);
    checkOutput("async pc", pc, 16'h0000);
    checkOutput("async valid", instr_valid, 0);
    checkOutput("async data", instr_data, 16'h0000);
    checkOutput("async ipc", instr_pc, 16'h0000);
    en = 1'b0; imem_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 1, 16'h5A5A, 1, 0, 16'h0000);
    checkOutput("stray rvalid", instr_valid, 0);

    // Withdrawn request, idle redirect, redirect with ready in HOLD.
    applyStimulus(1, 0, 0, 16'h0000, 1, 0, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0, 16'h0000);
    checkOutput("withdrawn req", imem_req, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 1, 16'h0100);
    checkOutput("idle redirect pc", pc, 16'h0100);
    applyStimulus(1, 0, 0, 16'h0000, 0, 0, 16'h0000);
    applyStimulus(1, 1, 0, 16'h0000, 0, 0, 16'h0000);
    applyStimulus(1, 0, 1, 16'h7777, 0, 0, 16'h0000);
    checkOutput("hold ipc", instr_pc, 16'h0100);
    applyStimulus(0, 0, 0, 16'h0000, 1, 1, 16'h0201);
    checkOutput("hold redirect valid", instr_valid, 0);
    checkOutput("hold redirect pc", pc, 16'h0200);
    checkOutput("hold redirect req", imem_req, 0);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
